// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width; never narrower than one bit, even for WIDTH=1.
    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtract.sv
// Combinational 1-bit full subtractor: a - b - borrowIn.
module full_subtract (
    output logic diff,
    output logic borrowOut,
    input  logic a,
    input  logic b,
    input  logic borrowIn
);

    assign diff      = a ^ b ^ borrowIn;
    assign borrowOut = (~a & b) | (~(a ^ b) & borrowIn);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock through a single
// full-subtract cell, with start/done handshake and held result/flags.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             cell_d, cell_bo;
    logic             accept, finish;

    full_subtract u_cell (
        .diff      (cell_d),
        .borrowOut (cell_bo),
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .borrowIn  (brw)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            done       <= 1'b0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sr       <= a;
                b_sr       <= b;
                diff_sr    <= '0;
                brw        <= borrow_in;
                cnt        <= '0;
                borrow_out <= 1'b0;
                overflow   <= 1'b0;
            end else if (state == SHIFT) begin
                // Shift-in written as OR of shifts so WIDTH=1 needs no special case.
                diff_sr <= (diff_sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                brw     <= cell_bo;
                cnt     <= cnt + CNT_W'(1);
                if (finish) begin
                    borrow_out <= cell_bo;
                    overflow   <= brw ^ cell_bo;
                    done       <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == SHIFT);
    assign diff = diff_sr;

endmodule
